wb_initiator: RTL and testbench

- Wishbone classic (B4, non-pipelined) bus initiator: the requesting end of the `wbs_*` slave interface used at the user-area boundary.
- Converts one command from a valid/ready command channel into one single-beat Wishbone cycle.
- Returns read data or a timeout error on a valid/ready response channel.
- Used inside the mixed-signal top to let local controllers (LA-driven sequencer, test logic) access Wishbone-mapped register blocks.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_timeout_ctr.sv | 39 +++
 rtl/wb_initiator.sv | 143 ++++++++++++++
 tb/tb_wb_initiator.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone classic initiator.
// Provides the FSM state type, the default bus widths and the timer-width helper.
package wb_pkg;

   typedef enum logic [1:0] {IDLE, BUS, RESP} wb_init_state_t;

   localparam int unsigned WB_ADR_W = 32;
   localparam int unsigned WB_DAT_W = 32;
   localparam int unsigned WB_SEL_W = 4;

   // Smallest width that can hold the value TIMEOUT, i.e. ceil(log2(TIMEOUT+1)).
   function automatic int unsigned clog2_timeout(input int unsigned timeout);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < (timeout + 32'd1)) begin
         w = w + 32'd1;
      end
      return w;
   endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Bus-cycle watchdog: counts STB cycles and flags the last permitted one.
// Saturates at TIMEOUT-1 so it never wraps while a cycle is outstanding.
module wb_timeout_ctr
   import wb_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = clog2_timeout(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && (count_q != LAST)) begin
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = (count_q == LAST);

endmodule

// File: rtl/wb_initiator.sv
// Wishbone B4 classic initiator: one command in, one single-beat bus cycle out,
// one response (read data or timeout error) back.
module wb_initiator
   import wb_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned ADR_W   = WB_ADR_W,
   parameter int unsigned DAT_W   = WB_DAT_W,
   parameter int unsigned SEL_W   = DAT_W / 8
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_ni,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_we,
   input  logic [ADR_W-1:0] cmd_adr,
   input  logic [DAT_W-1:0] cmd_dat,
   input  logic [SEL_W-1:0] cmd_sel,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [DAT_W-1:0] rsp_dat,
   output logic             rsp_err,
   output logic             wbm_cyc_o,
   output logic             wbm_stb_o,
   output logic             wbm_we_o,
   output logic [SEL_W-1:0] wbm_sel_o,
   output logic [ADR_W-1:0] wbm_adr_o,
   output logic [DAT_W-1:0] wbm_dat_o,
   input  logic [DAT_W-1:0] wbm_dat_i,
   input  logic             wbm_ack_i,
   output logic             busy
);

   wb_init_state_t   state_q, state_d;
   logic             cyc_q, cyc_d;
   logic             we_q, we_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [ADR_W-1:0] adr_q, adr_d;
   logic [DAT_W-1:0] dat_q, dat_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [DAT_W-1:0] rsp_dat_q, rsp_dat_d;
   logic             rsp_err_q, rsp_err_d;
   logic             tmr_clear, tmr_enable, tmr_expired;

   wb_timeout_ctr #(
      .TIMEOUT(TIMEOUT)
   ) u_timeout_ctr (
      .clk    (wb_clk_i),
      .rst_n  (wb_rst_ni),
      .clear  (tmr_clear),
      .enable (tmr_enable),
      .expired(tmr_expired)
   );

   always_comb begin
      state_d     = state_q;
      cyc_d       = cyc_q;
      we_d        = we_q;
      sel_d       = sel_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      rsp_valid_d = rsp_valid_q;
      rsp_dat_d   = rsp_dat_q;
      rsp_err_d   = rsp_err_q;
      tmr_clear   = 1'b0;
      tmr_enable  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               we_d      = cmd_we;
               sel_d     = cmd_sel;
               adr_d     = cmd_adr;
               dat_d     = cmd_dat;
               cyc_d     = 1'b1;
               tmr_clear = 1'b1;
               state_d   = BUS;
            end
         end
         BUS: begin
            // ACK is tested first so an ACK on the expiry edge completes normally.
            if (wbm_ack_i) begin
               cyc_d       = 1'b0;
               rsp_dat_d   = we_q ? '0 : wbm_dat_i;
               rsp_err_d   = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else if (tmr_expired) begin
               cyc_d       = 1'b0;
               rsp_dat_d   = '0;
               rsp_err_d   = 1'b1;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else begin
               tmr_enable = 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q     <= IDLE;
         cyc_q       <= 1'b0;
         we_q        <= 1'b0;
         sel_q       <= '0;
         adr_q       <= '0;
         dat_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_dat_q   <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cyc_q       <= cyc_d;
         we_q        <= we_d;
         sel_q       <= sel_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_dat_q   <= rsp_dat_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign cmd_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign wbm_cyc_o = cyc_q;
   assign wbm_stb_o = cyc_q;
   assign wbm_we_o  = we_q;
   assign wbm_sel_o = sel_q;
   assign wbm_adr_o = adr_q;
   assign wbm_dat_o = dat_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_dat   = rsp_dat_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Bench for wb_initiator: directed and randomized single-beat transactions against
// a transaction-level expectation model, plus backpressure and reset cases.
module tb_wb_initiator;

   localparam int unsigned TO = 8;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [31:0] cmd_adr, cmd_dat;
   logic [3:0]  cmd_sel;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_dat;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
   logic        busy;

   int tests = 0;
   int fails = 0;

   logic [31:0] exp_rdat;
   logic        exp_rerr;

   wb_initiator #(
      .TIMEOUT(TO),
      .ADR_W  (32),
      .DAT_W  (32),
      .SEL_W  (4)
   ) dut (
      .wb_clk_i (clk),
      .wb_rst_ni(rst_n),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_we   (cmd_we),
      .cmd_adr  (cmd_adr),
      .cmd_dat  (cmd_dat),
      .cmd_sel  (cmd_sel),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_dat  (rsp_dat),
      .rsp_err  (rsp_err),
      .wbm_cyc_o(wbm_cyc_o),
      .wbm_stb_o(wbm_stb_o),
      .wbm_we_o (wbm_we_o),
      .wbm_sel_o(wbm_sel_o),
      .wbm_adr_o(wbm_adr_o),
      .wbm_dat_o(wbm_dat_o),
      .wbm_dat_i(wbm_dat_i),
      .wbm_ack_i(wbm_ack_i),
      .busy     (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one command; the responder ACKs in STB cycle wait_n (0-based), or never
   // if wait_n >= TO. Leaves the bench sitting in the first response cycle.
   task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int wait_n, input logic [31:0] rdat);
      int n_stb;
      int exp_stb;
      cmd_we    = we;
      cmd_adr   = adr;
      cmd_dat   = dat;
      cmd_sel   = sel;
      cmd_valid = 1'b1;
      check("cmd_ready_before_accept", 64'(cmd_ready), 64'd1);
      step();
      cmd_valid = 1'b0;
      n_stb = 0;
      while (wbm_cyc_o === 1'b1 && n_stb < int'(TO) + 4) begin
         n_stb++;
         check("stb_high", 64'(wbm_stb_o), 64'd1);
         check("adr_stable", 64'(wbm_adr_o), 64'(adr));
         check("we_stable", 64'(wbm_we_o), 64'(we));
         check("sel_stable", 64'(wbm_sel_o), 64'(sel));
         check("dat_o_stable", 64'(wbm_dat_o), 64'(dat));
         check("cmd_ready_in_bus", 64'(cmd_ready), 64'd0);
         if (n_stb - 1 == wait_n) begin
            wbm_ack_i = 1'b1;
            wbm_dat_i = rdat;
         end else begin
            wbm_ack_i = 1'b0;
            wbm_dat_i = $urandom;
         end
         step();
         wbm_ack_i = 1'b0;
      end
      exp_stb  = (wait_n < int'(TO)) ? wait_n + 1 : int'(TO);
      exp_rerr = (wait_n >= int'(TO));
      exp_rdat = (exp_rerr || we) ? 32'd0 : rdat;
      check("stb_cycle_count", 64'(n_stb), 64'(exp_stb));
      check("stb_low_after", 64'(wbm_stb_o), 64'd0);
      check("rsp_valid_rise", 64'(rsp_valid), 64'd1);
      check("rsp_dat", 64'(rsp_dat), 64'(exp_rdat));
      check("rsp_err", 64'(rsp_err), 64'(exp_rerr));
      check("busy_in_resp", 64'(busy), 64'd1);
   endtask

   // Hold off the response for `hold` cycles, then handshake.
   task automatic drain(input int hold, input bit spurious);
      rsp_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         if (spurious && i == 1) wbm_ack_i = 1'b1;
         step();
         wbm_ack_i = 1'b0;
         check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
         check("bp_rsp_dat", 64'(rsp_dat), 64'(exp_rdat));
         check("bp_rsp_err", 64'(rsp_err), 64'(exp_rerr));
         check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check("rsp_valid_after_hs", 64'(rsp_valid), 64'd0);
      check("cmd_ready_after_hs", 64'(cmd_ready), 64'd1);
   endtask

   initial begin
      int wait_n;
      logic we;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_we    = 1'b0;
      cmd_adr   = '0;
      cmd_dat   = '0;
      cmd_sel   = '0;
      rsp_ready = 1'b0;
      wbm_ack_i = 1'b0;
      wbm_dat_i = '0;
      #12;
      check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      check("rst_cyc", 64'(wbm_cyc_o), 64'd0);
      check("rst_stb", 64'(wbm_stb_o), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_bus_fields", {wbm_we_o, wbm_sel_o, wbm_adr_o}, 64'd0);
      check("rst_rsp_fields", {rsp_err, rsp_dat}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Zero-wait read.
      issue(1'b0, 32'h3000_0004, 32'h0, 4'hF, 0, 32'hDEAD_BEEF);
      drain(0, 1'b0);
      // Write with five wait states.
      issue(1'b1, 32'h3000_0010, 32'h1234_5678, 4'h3, 5, 32'hFFFF_FFFF);
      drain(0, 1'b0);
      // No ACK at all: timeout.
      issue(1'b0, 32'h3000_0020, 32'h0, 4'hF, 100, 32'h0);
      drain(1, 1'b0);
      // ACK on the expiry edge.
      issue(1'b0, 32'h3000_0024, 32'h0, 4'hF, int'(TO) - 1, 32'hA5A5_A5A5);
      drain(0, 1'b0);

      // Backpressure with a spurious ACK in RESP and a queued second command.
      issue(1'b0, 32'h3000_0030, 32'h0, 4'hF, 2, 32'h0BAD_F00D);
      cmd_we    = 1'b1;
      cmd_adr   = 32'h3000_0034;
      cmd_dat   = 32'h5555_AAAA;
      cmd_sel   = 4'hC;
      cmd_valid = 1'b1;
      drain(4, 1'b1);
      issue(1'b1, 32'h3000_0034, 32'h5555_AAAA, 4'hC, 1, 32'h0);
      drain(0, 1'b0);

      // Spurious ACK while idle.
      wbm_ack_i = 1'b1;
      step();
      wbm_ack_i = 1'b0;
      step();
      check("idle_ack_no_rsp", 64'(rsp_valid), 64'd0);
      check("idle_ack_no_cyc", 64'(wbm_cyc_o), 64'd0);
      check("idle_ack_busy", 64'(busy), 64'd0);

      // Randomized transactions.
      for (int k = 0; k < 24; k++) begin
         we     = 1'($urandom_range(0, 1));
         wait_n = ($urandom_range(0, 5) == 0) ? int'(TO) + 3 : int'($urandom_range(0, 6));
         issue(we, $urandom, $urandom, 4'($urandom), wait_n, $urandom);
         drain(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      // Reset two cycles into a waited read.
      cmd_we    = 1'b0;
      cmd_adr   = 32'h3000_0040;
      cmd_sel   = 4'hF;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      check("mid_bus_cyc", 64'(wbm_cyc_o), 64'd1);
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_cyc", 64'(wbm_cyc_o), 64'd0);
      check("async_rst_stb", 64'(wbm_stb_o), 64'd0);
      check("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("async_rst_cmd_ready", 64'(cmd_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wbm_ack_i = (i == 1);
         wbm_dat_i = $urandom;
         step();
         wbm_ack_i = 1'b0;
         check("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
         check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
